// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage
// pipeline. Owns the PC, issues one instruction-memory read per cycle and
// hands the fetched instruction, its PC and PC+4 to the decode stage.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   hold_pc         load-use stall: keep the PC
//   hold_if         load-use stall: keep the IF/ID contents
//   if_flush        taken branch in ID: squash the instruction being fetched
//   branch_target   redirect address, used when if_flush=1
//   imem_req        fetch request (registered, low in the START cycle)
//   imem_addr       fetch address, equal to the PC
//   imem_rdata      fetched instruction, valid with imem_ready
//   imem_ready      instruction memory returns data this cycle
//   pc_id           PC of the instruction in ID
//   pc_plus4_id     pc_id + 4
//   instr_id        instruction in ID
//   valid_id        ID holds a real instruction (0 = bubble)
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   stall_cnt, flush_cnt, bubble_cnt  32-bit saturating event counters
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold_pc,
   input  logic                  hold_if,
   input  logic                  if_flush,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  imem_ready,
   output logic [ADDR_WIDTH-1:0] pc_id,
   output logic [ADDR_WIDTH-1:0] pc_plus4_id,
   output logic [DATA_WIDTH-1:0] instr_id,
`ifdef FETCH_PERF_CNT_EN
   output logic                  valid_id,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt,
   output logic [31:0]           bubble_cnt
`else
   output logic                  valid_id
`endif
);

   typedef enum logic {
      ST_START,
      ST_FETCH
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_plus4;

   // PC+4 wraps naturally at the top of the address space.
   assign pc_plus4  = pc + ADDR_WIDTH'(4);
   assign imem_addr = pc;

   // Sequencer, PC and IF/ID register. START lasts exactly one cycle after
   // reset release; hold beats flush so a branch that coincides with a stall
   // stays in ID and re-asserts if_flush once the stall clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_START;
         imem_req    <= 1'b0;
         pc          <= RESET_PC;
         pc_id       <= '0;
         pc_plus4_id <= '0;
         instr_id    <= NOP_INSTR;
         valid_id    <= 1'b0;
      end else begin
         state    <= ST_FETCH;
         imem_req <= 1'b1;

         if (state == ST_START) begin
            pc <= RESET_PC;
         end else if (hold_pc) begin
            pc <= pc;
         end else if (if_flush) begin
            pc <= branch_target;
         end else if (imem_ready) begin
            pc <= pc_plus4;
         end

         if (hold_if) begin
            valid_id <= valid_id;
         end else if (if_flush) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
         end else if ((state == ST_START) || !imem_ready) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
         end else begin
            instr_id    <= imem_rdata;
            pc_id       <= pc;
            pc_plus4_id <= pc_plus4;
            valid_id    <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Event counters only count while fetching; each event class is mutually
   // exclusive by the same priority the PC update uses. They stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (state == ST_FETCH) begin
         if (hold_pc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (if_flush && !hold_pc && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
         if (!imem_ready && !hold_pc && !if_flush && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed, self-checking bench for if_fetch_stage. A second instance with
// RESET_PC near the top of the address space exercises PC wrap-around.
// Instruction memory is modelled as instr = addr ^ KEY, available every
// cycle unless imem_ready is pulled low.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [31:0] KEY   = 32'hDEAD_0000;
   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] WRAPR = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst_n;
   logic        hold_pc;
   logic        hold_if;
   logic        if_flush;
   logic [31:0] branch_target;
   logic        imem_ready;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_id;
   logic [31:0] pc_plus4_id;
   logic [31:0] instr_id;
   logic        valid_id;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic [31:0] w_pc_id;
   logic [31:0] w_pc_plus4_id;
   logic [31:0] w_instr_id;
   logic        w_valid_id;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] bubble_cnt;
   logic [31:0] w_stall_cnt;
   logic [31:0] w_flush_cnt;
   logic [31:0] w_bubble_cnt;
`endif

   int tests;
   int fails;

   assign imem_rdata = imem_addr ^ KEY;
   assign w_rdata    = w_addr ^ KEY;

   if_fetch_stage #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hold_pc(hold_pc), .hold_if(hold_if),
      .if_flush(if_flush), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
      .instr_id(instr_id),
`ifdef FETCH_PERF_CNT_EN
      .valid_id(valid_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .bubble_cnt(bubble_cnt)
`else
      .valid_id(valid_id)
`endif
   );

   if_fetch_stage #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(WRAPR), .NOP_INSTR(NOP)
   ) u_wrap (
      .clk(clk), .rst_n(rst_n), .hold_pc(hold_pc), .hold_if(hold_if),
      .if_flush(if_flush), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .imem_ready(imem_ready), .pc_id(w_pc_id), .pc_plus4_id(w_pc_plus4_id),
      .instr_id(w_instr_id),
`ifdef FETCH_PERF_CNT_EN
      .valid_id(w_valid_id), .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt),
      .bubble_cnt(w_bubble_cnt)
`else
      .valid_id(w_valid_id)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare the main instance's fetch address and full IF/ID state.
   task automatic check_main(input string name, input logic [31:0] e_addr,
                             input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_valid);
      tests++;
      if (imem_addr !== e_addr || pc_id !== e_pc || pc_plus4_id !== e_pc + 32'd4 ||
          instr_id !== e_instr || valid_id !== e_valid) begin
         fails++;
         $display("[TB] FAIL %s: addr=%h pc_id=%h pc4=%h instr=%h valid=%b, want addr=%h pc_id=%h pc4=%h instr=%h valid=%b",
                  name, imem_addr, pc_id, pc_plus4_id, instr_id, valid_id,
                  e_addr, e_pc, e_pc + 32'd4, e_instr, e_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hold_pc = 1'b0; hold_if = 1'b0; if_flush = 1'b0;
      branch_target = '0; imem_ready = 1'b1;
      #3;
      tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_id !== 32'h0 ||
          pc_plus4_id !== 32'h0 || instr_id !== NOP || valid_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset: req=%b addr=%h pc_id=%h pc4=%h instr=%h valid=%b, want all zero",
                  imem_req, imem_addr, pc_id, pc_plus4_id, instr_id, valid_id);
      end
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      step();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL start: req=%b addr=%h valid=%b, want 1 00000000 0",
                  imem_req, imem_addr, valid_id);
      end
      for (int k = 2; k <= 5; k++) begin
         step();
         check_main("seq", 32'(4 * (k - 1)), 32'(4 * (k - 2)),
                    32'(4 * (k - 2)) ^ KEY, 1'b1);
      end
   endtask

   task automatic test_hold();
      hold_pc = 1'b1; hold_if = 1'b1;
      step();
      check_main("hold1", 32'h10, 32'h0C, 32'h0C ^ KEY, 1'b1);
      step();
      check_main("hold2", 32'h10, 32'h0C, 32'h0C ^ KEY, 1'b1);
      hold_pc = 1'b0; hold_if = 1'b0;
      step();
      check_main("resume", 32'h14, 32'h10, 32'h10 ^ KEY, 1'b1);
      step();
      step();
      step();
      check_main("pre_branch", 32'h20, 32'h1C, 32'h1C ^ KEY, 1'b1);
   endtask

   task automatic test_flush();
      if_flush = 1'b1; branch_target = 32'h100;
      step();
      check_main("flush", 32'h100, 32'h1C, NOP, 1'b0);
      if_flush = 1'b0;
      step();
      check_main("target", 32'h104, 32'h100, 32'h100 ^ KEY, 1'b1);
      step();
      check_main("target+4", 32'h108, 32'h104, 32'h104 ^ KEY, 1'b1);
   endtask

   task automatic test_hold_flush();
      hold_pc = 1'b1; hold_if = 1'b1; if_flush = 1'b1; branch_target = 32'h200;
      step();
      check_main("hold_beats_flush", 32'h108, 32'h104, 32'h104 ^ KEY, 1'b1);
      hold_pc = 1'b0; hold_if = 1'b0;
      step();
      check_main("late_flush", 32'h200, 32'h104, NOP, 1'b0);
      if_flush = 1'b0;
      step();
      check_main("late_target", 32'h204, 32'h200, 32'h200 ^ KEY, 1'b1);
   endtask

   task automatic test_not_ready();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (imem_addr !== 32'h204 || instr_id !== NOP || valid_id !== 1'b0) begin
            fails++;
            $display("[TB] FAIL not_ready%0d: addr=%h instr=%h valid=%b, want 00000204 %h 0",
                     i, imem_addr, instr_id, valid_id, NOP);
         end
      end
      imem_ready = 1'b1;
      step();
      check_main("ready_again", 32'h208, 32'h204, 32'h204 ^ KEY, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      tests++;
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2 || bubble_cnt !== 32'd3) begin
         fails++;
         $display("[TB] FAIL perf_cnt: stall=%0d flush=%0d bubble=%0d, want 3 2 3",
                  stall_cnt, flush_cnt, bubble_cnt);
      end
`endif
   endtask

   task automatic test_mid_reset();
      rst_n = 1'b0;
      #1;
      tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc_id !== 32'h0 ||
          instr_id !== NOP || valid_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mid_reset: req=%b addr=%h pc_id=%h instr=%h valid=%b, want 0 0 0 %h 0",
                  imem_req, imem_addr, pc_id, instr_id, valid_id, NOP);
      end
      step();
      rst_n = 1'b1;
      step();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL restart: req=%b addr=%h valid=%b, want 1 00000000 0",
                  imem_req, imem_addr, valid_id);
      end
      step();
      check_main("restart_fetch", 32'h4, 32'h0, 32'h0 ^ KEY, 1'b1);
   endtask

   task automatic test_wrap();
      rst_n = 1'b0;
      #1;
      tests++;
      if (w_addr !== WRAPR || w_pc_id !== 32'h0 || w_valid_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL wrap_reset: addr=%h pc_id=%h valid=%b, want %h 00000000 0",
                  w_addr, w_pc_id, w_valid_id, WRAPR);
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if (w_addr !== 32'hFFFF_FFFC || w_pc_id !== WRAPR || w_pc_plus4_id !== 32'hFFFF_FFFC ||
          w_instr_id !== (WRAPR ^ KEY) || w_valid_id !== 1'b1) begin
         fails++;
         $display("[TB] FAIL wrap_a: addr=%h pc_id=%h pc4=%h instr=%h valid=%b, want fffffffc fffffff8 fffffffc %h 1",
                  w_addr, w_pc_id, w_pc_plus4_id, w_instr_id, w_valid_id, WRAPR ^ KEY);
      end
      step();
      tests++;
      if (w_addr !== 32'h0 || w_pc_id !== 32'hFFFF_FFFC || w_pc_plus4_id !== 32'h0 ||
          w_valid_id !== 1'b1) begin
         fails++;
         $display("[TB] FAIL wrap_b: addr=%h pc_id=%h pc4=%h valid=%b, want 00000000 fffffffc 00000000 1",
                  w_addr, w_pc_id, w_pc_plus4_id, w_valid_id);
      end
      step();
      tests++;
      if (w_addr !== 32'h4 || w_pc_id !== 32'h0 || w_instr_id !== KEY) begin
         fails++;
         $display("[TB] FAIL wrap_c: addr=%h pc_id=%h instr=%h, want 00000004 00000000 %h",
                  w_addr, w_pc_id, w_instr_id, KEY);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_sequential();
      test_hold();
      test_flush();
      test_hold_flush();
      test_not_ready();
      test_mid_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
